// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W general-purpose register file with one
// synchronous write port and two combinational read ports (R and S).
// Registers clear asynchronously while reset is low, and a write attempted
// in that window is discarded.
// Optional build macro: REGFILE_BYPASS_EN adds write-through forwarding.
// When it is defined, a read port whose address matches W_Adr during an
// enabled write presents W in the same cycle.
// Interface timing: the write port has no valid/ready handshake. we is a
// single-cycle qualifier that is sampled on each rising clk edge, and the
// read ports are always valid with zero latency.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] W,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic              we,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    // Full one-hot decode of the write address; every code selects exactly one register
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = we && (W_Adr == ADDR_W'(i));
        end
    end

    // Register storage: async clear dominates, otherwise load the selected register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= W;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports with write-through forwarding of the in-flight write data
    always_comb begin
        R = regs[R_Adr];
        S = regs[S_Adr];
        if (we && reset && (R_Adr == W_Adr)) begin
            R = W;
        end
        if (we && reset && (S_Adr == W_Adr)) begin
            S = W;
        end
    end
`else
    // Read ports present stored contents only; a write becomes visible after its edge
    always_comb begin
        R = regs[R_Adr];
        S = regs[S_Adr];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] W;
    logic [ADDR_W-1:0] W_Adr;
    logic              we;
    logic [ADDR_W-1:0] R_Adr;
    logic [ADDR_W-1:0] S_Adr;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] S;

    int checks   = 0;
    int failures = 0;

    // Reference model: the architectural contents of each register
    logic [DATA_W-1:0] model [NREGS];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .W     (W),
        .W_Adr (W_Adr),
        .we    (we),
        .R_Adr (R_Adr),
        .S_Adr (S_Adr),
        .R     (R),
        .S     (S)
    );

    // Clock block: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected value seen on a read port at address a for the current inputs
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (!reset) return '0;
        if (BYPASS && we && (a == W_Adr)) return W;
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Write one register: drive at the falling edge, commit at the rising edge
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we = 1'b1; W_Adr = a; W = d;
        @(posedge clk);
        #1;
        model[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Sweep R over 0..3 and S over 4..7 and compare against the model
    task automatic sweep(input string tag);
        for (int i = 0; i < 4; i++) begin
            R_Adr = ADDR_W'(i);
            S_Adr = ADDR_W'(i + 4);
            #1;
            check({tag, "_R"}, R, exp_read(R_Adr));
            check({tag, "_S"}, S, exp_read(S_Adr));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        logic [DATA_W-1:0] old2;

        reset = 1'b0; we = 1'b0; W = '0; W_Adr = '0; R_Adr = '0; S_Adr = '0;
        model_clear();

        // Reset asserted: every address reads zero
        #2;
        check("reset_r0", R, 16'h0000);
        check("reset_s0", S, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sweep("post_reset");

        // Write 0x00AA >> i to each register, then read back on both ports
        for (int i = 0; i < NREGS; i++) begin
            pat = 16'h00AA >> i;
            do_write(ADDR_W'(i), pat);
        end
        sweep("pattern");
        check("pattern_r7_const", model[7], 16'h0001);

        // Same address on both ports
        R_Adr = 3'd5; S_Adr = 3'd5;
        #1;
        check("same_addr_r", R, 16'h0005);
        check("same_addr_s", S, 16'h0005);

        // we=0 holds registers even with data and address driven
        @(negedge clk);
        we = 1'b0; W = 16'hFFFF; W_Adr = 3'd3; R_Adr = 3'd3; S_Adr = 3'd3;
        repeat (4) @(posedge clk);
        #1;
        check("hold_r3", R, 16'h0015);
        check("hold_s3", S, 16'h0015);

        // Read of the written address before and after the edge
        old2 = model[2];
        @(negedge clk);
        we = 1'b1; W_Adr = 3'd2; W = 16'h1234; R_Adr = 3'd2; S_Adr = 3'd1;
        #1;
        check("wr_before_edge_r", R, BYPASS ? 16'h1234 : old2);
        check("wr_before_edge_s", S, 16'h0055);
        @(posedge clk);
        #1;
        model[2] = 16'h1234;
        check("wr_after_edge_r", R, 16'h1234);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("wr_settled_r", R, 16'h1234);

        // Reset mid-cycle with a pending write: clears immediately and drops the write
        @(negedge clk);
        we = 1'b1; W_Adr = 3'd6; W = 16'hBEEF; R_Adr = 3'd6; S_Adr = 3'd0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("midrst_r6", R, 16'h0000);
        check("midrst_s0", S, 16'h0000);
        @(posedge clk);
        #1;
        sweep("rst_held_write");
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        #1;
        R_Adr = 3'd6;
        #1;
        check("write_lost_r6", R, 16'h0000);

        // First write after release lands on the next enabled edge
        do_write(3'd4, 16'hC0DE);
        R_Adr = 3'd4; S_Adr = 3'd6;
        #1;
        check("first_write_r4", R, 16'hC0DE);
        check("first_write_s6", S, 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we    = ($urandom_range(0, 99) < 60);
            W     = DATA_W'($urandom);
            W_Adr = ADDR_W'($urandom_range(0, NREGS - 1));
            R_Adr = ADDR_W'($urandom_range(0, NREGS - 1));
            S_Adr = ($urandom_range(0, 3) == 0) ? W_Adr : ADDR_W'($urandom_range(0, NREGS - 1));
            #1;
            check("rand_pre_r", R, exp_read(R_Adr));
            check("rand_pre_s", S, exp_read(S_Adr));
            @(posedge clk);
            #1;
            if (we) model[W_Adr] = W;
            check("rand_post_r", R, exp_read(R_Adr));
            check("rand_post_s", S, exp_read(S_Adr));
        end

        @(negedge clk);
        we = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) begin
            R_Adr = ADDR_W'(i);
            S_Adr = ADDR_W'(NREGS - 1 - i);
            #1;
            check("final_r", R, model[i]);
            check("final_s", S, model[NREGS - 1 - i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and set the register and data-port width in bits.
REQ-002 The parameter ADDR_W SHALL default to 3 and set the address width, giving 2**ADDR_W registers (8 by default).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all writes occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port W SHALL be an input, DATA_W bits wide: write data.
REQ-006 Port W_Adr SHALL be an input, ADDR_W bits wide: write address.
REQ-007 Port we SHALL be an input, 1 bit wide: write enable, active-high.
REQ-008 Port R_Adr SHALL be an input, ADDR_W bits wide: read address for port R.
REQ-009 Port S_Adr SHALL be an input, ADDR_W bits wide: read address for port S.
REQ-010 Port R SHALL be an output, DATA_W bits wide: read data for R_Adr.
REQ-011 Port S SHALL be an output, DATA_W bits wide: read data for S_Adr.

Function
REQ-012 The block SHALL hold 2**ADDR_W general registers of DATA_W bits each, and every register SHALL be writable.
REQ-013 On a rising clk edge with we=1 and reset=1, register[W_Adr] SHALL load W; all other registers SHALL hold their values.
REQ-014 With we=0, no register SHALL change on any clock edge.
REQ-015 R SHALL equal register[R_Adr] and S SHALL equal register[S_Adr] combinationally, with zero-cycle read latency.
REQ-016 When R_Adr equals S_Adr, R and S SHALL both present the same register value.
REQ-017 Without bypass (see REQ-022), a read of W_Adr during a write cycle SHALL return the old value until the clock edge and the new value after it.
REQ-018 Address decode SHALL cover all 2**ADDR_W codes, so no address is unused or aliased.

Reset
REQ-019 While reset=0, all registers SHALL be cleared to 0 immediately, without waiting for a clock edge, so R=0 and S=0 for any address.
REQ-020 Reset SHALL take priority over a simultaneous write; a write attempted while reset=0 SHALL be discarded.
REQ-021 After reset is released (reset=1), the first write SHALL take effect on the next rising clk edge with we=1.

Configuration
REQ-022 The macro REGFILE_BYPASS_EN SHALL control write-through forwarding:
- When defined: while we=1 and reset=1, a read port whose address equals W_Adr SHALL output W combinationally in the same cycle.
- When undefined: both read ports SHALL always output stored register contents only.

Verification
REQ-023 Apply reset=0, release it, then sweep R_Adr=0..3 with S_Adr=4..7 and we=0 -> R=0x0000 and S=0x0000 for every address.
REQ-024 Write register i = 0x00AA >> i for i=0..7 (0x00AA, 0x0055, 0x002A, 0x0015, 0x000A, 0x0005, 0x0002, 0x0001), then sweep R_Adr=0..3 and S_Adr=4..7 -> each output equals the value written to that address.
REQ-025 Hold we=0 with W=0xFFFF and W_Adr=3 for several edges -> register 3 keeps its previous value.
REQ-026 Set R_Adr=S_Adr=5 after the REQ-024 writes -> R=S=0x0005.
REQ-027 Assert reset=0 mid-clock, away from any edge, with we=1 -> R and S read 0x0000 immediately for every address, and the pending write is lost.
REQ-028 Set we=1, W_Adr=2, W=0x1234, R_Adr=2 before the edge:
- With REGFILE_BYPASS_EN defined -> R=0x1234 before the edge.
- Without it -> R holds the old value before the edge and reads 0x1234 after it.
